// File: rtl/parking_meter_core_pkg.sv
// Parking meter shared types: sensor and converter states,
// seven-segment code table and the credit ceiling helper.
package parking_meter_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S1   = 2'b01,
        S2   = 2'b10,
        S3   = 2'b11
    } sensor_state_t;

    typedef enum logic [1:0] {
        CV_IDLE  = 2'b00,
        CV_SHIFT = 2'b01,
        CV_DONE  = 2'b10
    } conv_state_t;

    // Active-low {dp,g,f,e,d,c,b,a}, dp held off.
    localparam logic [7:0] SEG_TABLE [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        return (d < 4'd10) ? SEG_TABLE[d] : SEG_BLANK;
    endfunction

    function automatic longint max_count(input int cnt_w, input int digits);
        longint dec;
        longint bin;
        dec = 1;
        for (int i = 0; i < digits; i++) dec = dec * 10;
        bin = (longint'(1) << cnt_w) - 1;
        return (bin < dec - 1) ? bin : dec - 1;
    endfunction

endpackage

// File: rtl/parking_meter_core_bcd.sv
// Sequential shift-add-3 binary to BCD converter.
// Snapshots bin on start, shifts CNT_W times, then pulses done.
module bin_to_bcd_seq
    import parking_meter_core_pkg::*;
#(
    parameter int CNT_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    bin,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int NW = $clog2(CNT_W + 1);

    conv_state_t         state;
    conv_state_t         state_next;
    logic [CNT_W-1:0]    shreg;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] acc_adj;
    logic [NW-1:0]       n;
    logic                last;

    assign last = (n == NW'(CNT_W - 1));
    assign done = (state == CV_DONE);
    assign bcd  = acc;

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= CV_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CV_IDLE:  if (start) state_next = CV_SHIFT;
            CV_SHIFT: if (last)  state_next = CV_DONE;
            CV_DONE:  state_next = CV_IDLE;
            default:  state_next = CV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            acc   <= '0;
            n     <= '0;
        end else begin
            case (state)
                CV_IDLE: begin
                    if (start) begin
                        shreg <= bin;
                        acc   <= '0;
                        n     <= '0;
                    end
                end
                CV_SHIFT: begin
                    acc   <= {acc_adj[4*DIGITS-2:0], shreg[CNT_W-1]};
                    shreg <= shreg << 1;
                    n     <= n + NW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/parking_meter_core.sv
// Parking meter core: coin sensor FSM, credit counter with
// time-unit prescaler, and multiplexed seven-segment display.
module parking_meter_core
    import parking_meter_core_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int CNT_W       = 14,
    parameter int CREDIT      = 15,
    parameter int TICK_DIV    = 50_000_000,
    parameter int REFRESH_DIV = 65_536,
    parameter int BLANK       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a,
    input  logic              b,
    output logic [CNT_W-1:0]  count,
    output logic              expired,
    output logic              coin_tick,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        sseg
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(max_count(CNT_W, DIGITS));
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    sensor_state_t       state;
    sensor_state_t       state_next;
    logic                coin;
    logic                tick;
    logic [TW-1:0]       tick_cnt;
    logic [RW-1:0]       ref_cnt;
    logic [DW-1:0]       idx;
    logic [CNT_W:0]      sum;
    logic [CNT_W-1:0]    sat;
    logic [CNT_W-1:0]    count_next;
    logic                conv_done;
    logic [4*DIGITS-1:0] conv_bcd;
    logic [4*DIGITS-1:0] disp;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          cur;

    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign expired   = (count == '0);
    assign coin_tick = coin;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Out-of-order patterns hold; only 00 escapes early, without a coin.
    always_comb begin
        state_next = state;
        coin       = 1'b0;
        case (state)
            IDLE: if (a && !b) state_next = S1;
            S1: begin
                if (a && b)        state_next = S2;
                else if (!a && !b) state_next = IDLE;
            end
            S2: begin
                if (!a && b)       state_next = S3;
                else if (!a && !b) state_next = IDLE;
            end
            S3: begin
                if (!a && !b) begin
                    state_next = IDLE;
                    coin       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sum = {1'b0, count} + (CNT_W+1)'(CREDIT);
    assign sat = (sum > {1'b0, MAX}) ? MAX : sum[CNT_W-1:0];

    always_comb begin
        count_next = count;
        if (coin)
            count_next = tick ? sat - CNT_W'(1) : sat;
        else if (tick && count != '0)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            tick_cnt <= '0;
            ref_cnt  <= '0;
            idx      <= '0;
            disp     <= '0;
        end else begin
            count    <= count_next;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= (idx == DW'(DIGITS - 1)) ? '0 : idx + DW'(1);
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
            if (conv_done) disp <= conv_bcd;
        end
    end

    bin_to_bcd_seq #(
        .CNT_W  (CNT_W),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (1'b1),
        .bin   (count),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Digit 0 is never blanked so an empty meter still reads 0.
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int d = DIGITS - 1; d > 0; d--) begin
            zero_above = zero_above & (disp[4*d +: 4] == 4'd0);
            blank[d]   = (BLANK != 0) & zero_above;
        end
    end

    assign cur  = disp[{idx, 2'b00} +: 4];
    assign an   = blank[idx] ? '1 : ~(DIGITS'(1) << idx);
    assign sseg = blank[idx] ? SEG_BLANK : seg_code(cur);

endmodule
